// File: rtl/input_source_arbiter.sv
// rtl/input_source_arbiter.sv - picks which input device (NES, PS/2, IR VCR) drives the shared display mux
module input_source_arbiter #(
   parameter int HOLD_CYCLES      = 50_000_000,
   parameter int MIN_GRANT_CYCLES = 5_000_000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_nes_state,
   input  logic [13:0] i_ps2_code,
   input  logic [6:0]  i_vcr_code,
   input  logic        i_vcr_valid,
   input  logic        i_manual_en,
   input  logic [1:0]  i_manual_sel,
   output logic [1:0]  o_sel,
   output logic        o_busy,
   output logic        o_switch_pulse
);

   localparam int HW = $clog2(HOLD_CYCLES);
   localparam int EW = $clog2(MIN_GRANT_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [EW-1:0] ELAPSED_MAX = EW'(MIN_GRANT_CYCLES);

   typedef enum logic [1:0] {S_PRIME, S_IDLE, S_HOLD, S_MANUAL} state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_sel, w_sel_nxt;
   logic          r_pulse;
   logic [HW-1:0] r_hold_cnt, w_hold_nxt;
   logic [EW-1:0] r_elapsed, w_elapsed_nxt, w_elapsed_inc;
   logic [7:0]    r_prev_nes;
   logic [13:0]   r_prev_ps2;
   logic [6:0]    r_prev_vcr;
   logic          r_prev_valid;

   logic          w_act_nes, w_act_ps2, w_act_vcr;
   logic [3:0]    w_act;
   logic [1:0]    w_new_sel, w_other_sel;

   // A held NES button counts as activity every cycle, not just on change.
   assign w_act_nes = (i_nes_state != 8'd0) | (i_nes_state != r_prev_nes);
   assign w_act_ps2 = (i_ps2_code != r_prev_ps2);
   assign w_act_vcr = (i_vcr_valid & ~r_prev_valid) | (i_vcr_valid & (i_vcr_code != r_prev_vcr));
   assign w_act     = {w_act_vcr, w_act_ps2, w_act_nes, 1'b0};

   assign w_elapsed_inc = (r_elapsed >= ELAPSED_MAX) ? r_elapsed : r_elapsed + EW'(1);

   always_comb begin
      w_new_sel = 2'd0;
      if (w_act_vcr)      w_new_sel = 2'd3;
      else if (w_act_ps2) w_new_sel = 2'd2;
      else if (w_act_nes) w_new_sel = 2'd1;
   end

   always_comb begin
      w_other_sel = 2'd0;
      if (w_act_vcr && r_sel != 2'd3)      w_other_sel = 2'd3;
      else if (w_act_ps2 && r_sel != 2'd2) w_other_sel = 2'd2;
      else if (w_act_nes && r_sel != 2'd1) w_other_sel = 2'd1;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_sel_nxt     = r_sel;
      w_hold_nxt    = r_hold_cnt;
      w_elapsed_nxt = r_elapsed;
      case (r_state)
         S_PRIME: begin
            w_state_nxt   = i_manual_en ? S_MANUAL : S_IDLE;
            w_sel_nxt     = 2'd0;
            w_hold_nxt    = '0;
            w_elapsed_nxt = '0;
         end
         S_IDLE: begin
            if (i_manual_en) begin
               w_state_nxt = S_MANUAL;
               w_sel_nxt   = i_manual_sel;
            end else if (w_new_sel != 2'd0) begin
               w_state_nxt   = S_HOLD;
               w_sel_nxt     = w_new_sel;
               w_hold_nxt    = HOLD_RELOAD;
               w_elapsed_nxt = '0;
            end
         end
         S_HOLD: begin
            if (i_manual_en) begin
               w_state_nxt   = S_MANUAL;
               w_sel_nxt     = i_manual_sel;
               w_hold_nxt    = '0;
               w_elapsed_nxt = '0;
            end else if (w_act[r_sel]) begin
               w_hold_nxt    = HOLD_RELOAD;
               w_elapsed_nxt = w_elapsed_inc;
            end else if (w_other_sel != 2'd0 && r_elapsed >= ELAPSED_MAX) begin
               w_sel_nxt     = w_other_sel;
               w_hold_nxt    = HOLD_RELOAD;
               w_elapsed_nxt = '0;
            end else if (r_hold_cnt == '0) begin
               w_state_nxt   = S_IDLE;
               w_sel_nxt     = 2'd0;
               w_elapsed_nxt = '0;
            end else begin
               w_hold_nxt    = r_hold_cnt - HW'(1);
               w_elapsed_nxt = w_elapsed_inc;
            end
         end
         default: begin
            if (i_manual_en) begin
               w_sel_nxt = i_manual_sel;
            end else begin
               w_state_nxt   = S_IDLE;
               w_sel_nxt     = 2'd0;
               w_hold_nxt    = '0;
               w_elapsed_nxt = '0;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_PRIME;
         r_sel        <= 2'd0;
         r_pulse      <= 1'b0;
         r_hold_cnt   <= '0;
         r_elapsed    <= '0;
         r_prev_nes   <= 8'd0;
         r_prev_ps2   <= 14'd0;
         r_prev_vcr   <= 7'd0;
         r_prev_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sel        <= w_sel_nxt;
         r_pulse      <= (w_sel_nxt != r_sel);
         r_hold_cnt   <= w_hold_nxt;
         r_elapsed    <= w_elapsed_nxt;
         r_prev_nes   <= i_nes_state;
         r_prev_ps2   <= i_ps2_code;
         r_prev_vcr   <= i_vcr_code;
         r_prev_valid <= i_vcr_valid;
      end
   end

   assign o_sel          = r_sel;
   assign o_busy         = (r_state == S_HOLD);
   assign o_switch_pulse = r_pulse;

endmodule

// File: tb/tb_input_source_arbiter.sv
// tb/tb_input_source_arbiter.sv - scoreboard bench for input_source_arbiter with a timestamp reference model
module tb_input_source_arbiter;

   localparam int HOLD = 16;
   localparam int MING = 4;

   logic        clk;
   logic        rst;
   logic [7:0]  nes;
   logic [13:0] ps2;
   logic [6:0]  vcr;
   logic        valid;
   logic        man_en;
   logic [1:0]  man_sel;
   logic [1:0]  o_sel;
   logic        o_busy;
   logic        o_pulse;

   input_source_arbiter #(.HOLD_CYCLES(HOLD), .MIN_GRANT_CYCLES(MING)) dut (
      .i_clk(clk), .i_reset(rst), .i_nes_state(nes), .i_ps2_code(ps2),
      .i_vcr_code(vcr), .i_vcr_valid(valid), .i_manual_en(man_en),
      .i_manual_sel(man_sel), .o_sel(o_sel), .o_busy(o_busy), .o_switch_pulse(o_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int sel;
      int busy;
      int pulse;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 prime, 1 idle, 2 hold, 3 manual; timing from cycle stamps.
   int m_mode = 0;
   int m_sel = 0;
   int m_grant = 0;
   int m_refresh = 0;
   int m_t = 0;
   logic [7:0]  p_nes = 0;
   logic [13:0] p_ps2 = 0;
   logic [6:0]  p_vcr = 0;
   logic        p_valid = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int pick(input bit an, input bit ap, input bit av, input int excl);
      if (av && excl != 3) return 3;
      if (ap && excl != 2) return 2;
      if (an && excl != 1) return 1;
      return 0;
   endfunction

   task automatic m_step();
      exp_t e;
      int old, other;
      bit an, ap, av, own;
      old = m_sel;
      e.pulse = 0;
      if (rst) begin
         m_mode = 0; m_sel = 0;
         p_nes = 0; p_ps2 = 0; p_vcr = 0; p_valid = 0;
      end else begin
         an = (nes != 0) || (nes != p_nes);
         ap = (ps2 != p_ps2);
         av = valid && (!p_valid || vcr != p_vcr);
         if (m_mode == 0) begin
            m_mode = man_en ? 3 : 1; m_sel = 0;
         end else if (man_en) begin
            m_mode = 3; m_sel = man_sel;
         end else if (m_mode == 3) begin
            m_mode = 1; m_sel = 0;
         end else if (m_mode == 1) begin
            other = pick(an, ap, av, 0);
            if (other != 0) begin
               m_mode = 2; m_sel = other; m_grant = m_t; m_refresh = m_t;
            end
         end else begin
            own = (m_sel == 1) ? an : (m_sel == 2) ? ap : av;
            other = pick(an, ap, av, m_sel);
            if (own) m_refresh = m_t;
            else if (other != 0 && m_t - m_grant - 1 >= MING) begin
               m_sel = other; m_grant = m_t; m_refresh = m_t;
            end else if (m_t - m_refresh >= HOLD) begin
               m_mode = 1; m_sel = 0;
            end
         end
         p_nes = nes; p_ps2 = ps2; p_vcr = vcr; p_valid = valid;
         e.pulse = (m_sel != old) ? 1 : 0;
      end
      e.sel = m_sel;
      e.busy = (m_mode == 2) ? 1 : 0;
      q.push_back(e);
      m_t++;
   endtask

   task automatic cyc();
      m_step();
      @(posedge clk);
      #1;
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("sb_sel", int'(o_sel), e.sel);
         chk("sb_busy", int'(o_busy), e.busy);
         chk("sb_pulse", int'(o_pulse), e.pulse);
      end
   end

   initial begin
      int n;
      rst = 1; nes = 8'h01; ps2 = 0; vcr = 0; valid = 0; man_en = 0; man_sel = 0;
      // reset with a held NES button: PRIME cycle, then grant
      cyc();
      chk("reset_sel", int'(o_sel), 0);
      chk("reset_busy", int'(o_busy), 0);
      rst = 0;
      cyc();
      chk("prime_no_grant", int'(o_sel), 0);
      cyc();
      chk("t1_sel", int'(o_sel), 1);
      chk("t1_pulse", int'(o_pulse), 1);
      nes = 0;
      repeat (20) cyc();
      chk("t1_expired", int'(o_sel), 0);

      // single PS2 change, grant lasts until 17 cycles after the change
      ps2 = 14'h0A1;
      cyc();
      chk("t2_sel", int'(o_sel), 2);
      n = 0;
      do begin
         cyc();
         n++;
      end while (o_sel != 0 && n < 40);
      chk("t2_expiry_cycles", n + 1, 17);

      // NES grant protected from VCR until elapsed reaches MIN
      nes = 8'h01; cyc();
      nes = 8'h00; cyc();
      valid = 1; vcr = 7'h12; cyc();
      chk("t3_no_preempt", int'(o_sel), 1);
      valid = 0; cyc();
      cyc();
      valid = 1; cyc();
      chk("t3_preempt", int'(o_sel), 3);
      chk("t3_pulse", int'(o_pulse), 1);
      repeat (20) cyc();
      valid = 0; cyc(); cyc();

      // simultaneous PS2 and VCR from idle: VCR wins, one pulse
      ps2 = 14'h155; valid = 1; vcr = 7'h33; cyc();
      chk("t4_sel", int'(o_sel), 3);
      chk("t4_busy", int'(o_busy), 1);
      chk("t4_pulse", int'(o_pulse), 1);
      cyc();
      chk("t4_single_pulse", int'(o_pulse), 0);
      repeat (20) cyc();
      valid = 0; cyc(); cyc();

      // manual override from HOLD
      ps2 = 14'h2BC; cyc();
      chk("t5_hold_ps2", int'(o_sel), 2);
      man_en = 1; man_sel = 2'b01; cyc();
      chk("t5_manual_sel", int'(o_sel), 1);
      chk("t5_manual_busy", int'(o_busy), 0);
      man_en = 0; cyc();
      chk("t5_release", int'(o_sel), 0);

      // reset mid-grant
      nes = 8'h01; cyc(); cyc(); cyc();
      rst = 1; cyc();
      chk("t6_reset_sel", int'(o_sel), 0);
      chk("t6_reset_pulse", int'(o_pulse), 0);
      rst = 0; cyc();
      chk("t6_prime", int'(o_sel), 0);
      cyc();
      chk("t6_regrant", int'(o_sel), 1);
      nes = 0; cyc();

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) nes = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'd0;
         if ($urandom_range(0, 29) == 0) ps2 = 14'($urandom);
         if ($urandom_range(0, 24) == 0) valid = ~valid;
         if ($urandom_range(0, 24) == 0) vcr = 7'($urandom);
         if ($urandom_range(0, 249) == 0) man_en = ~man_en;
         if ($urandom_range(0, 9) == 0) man_sel = 2'($urandom);
         rst = ($urandom_range(0, 499) == 0);
         cyc();
      end
      rst = 0;
      cyc();

      repeat (3) @(posedge clk);
      #3;
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
